// File: rtl/i2s_receiver.sv
// ---------------------------------------------------------------------------
// i2s_receiver
//
// I2S slave receiver. BCLK, LRCLK and DIN are oversampled in the system clock
// domain and standard Philips I2S is deserialised: the MSB arrives one BCLK
// after the LRCLK edge, and LRCLK low selects the left channel. Complete
// left/right pairs are presented together with a one-cycle strobe.
//
// Parameters
//   WIDTH    output sample width. Longer slots are truncated and shorter
//            slots are zero-padded, so the sample stays left-aligned.
//   TIMEOUT  number of clk cycles without a BCLK rising edge before the
//            link is declared lost.
//
// Ports
//   i_clk            system clock (at least 4x the BCLK frequency)
//   i_reset          synchronous, active-high reset
//   i_i2s_bclk       asynchronous bit clock
//   i_i2s_lrclk      asynchronous word select (0 = left, 1 = right)
//   i_i2s_din        asynchronous serial data, MSB first
//   o_audio_l        last complete left sample (two's complement, left-aligned)
//   o_audio_r        last complete right sample, paired with o_audio_l
//   o_sample_valid   one-clk pulse: a new o_audio_l/o_audio_r pair was loaded
//   o_frame_err      one-clk pulse: a committed word held fewer than WIDTH bits
//   o_active         high while synced and BCLK is toggling
//
// Handshake: o_sample_valid is a pure strobe with no ready. The pair on
// o_audio_l/o_audio_r changes only on the edge that raises o_sample_valid
// and then holds until the next strobe, so a consumer may sample the pair
// in the strobe cycle or at any later time before the next strobe.
// ---------------------------------------------------------------------------
module i2s_receiver #(
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_i2s_bclk,
    input  logic             i_i2s_lrclk,
    input  logic             i_i2s_din,
    output logic [WIDTH-1:0] o_audio_l,
    output logic [WIDTH-1:0] o_audio_r,
    output logic             o_sample_valid,
    output logic             o_frame_err,
    output logic             o_active
);

    localparam int TW = $clog2(TIMEOUT + 1);

    // Synchronisers. BCLK carries one extra stage for edge detection.
    logic r_bclk_s1, r_bclk_s2, r_bclk_s3;
    logic r_lrclk_s1, r_lrclk_s2;
    logic r_din_s1, r_din_s2;

    // Deserialiser state.
    logic [WIDTH-1:0] r_shreg;
    logic [WIDTH-1:0] r_left_pend;
    logic [5:0]       r_bitcnt;
    logic             r_ws_prev;
    logic             r_synced;
    logic             r_have_left;
    logic [TW-1:0]    r_to_cnt;

    // Registered outputs.
    logic [WIDTH-1:0] r_audio_l;
    logic [WIDTH-1:0] r_audio_r;
    logic             r_sample_valid;
    logic             r_frame_err;
    logic             r_active;

    logic             w_rise;
    logic             w_boundary;
    logic             w_to_hit;
    logic [WIDTH-1:0] w_word;

    assign w_rise     = r_bclk_s2 & ~r_bclk_s3;
    assign w_boundary = (r_lrclk_s2 != r_ws_prev);
    // Next cycle would be the TIMEOUT-th one without a rise.
    assign w_to_hit   = (r_to_cnt == TW'(TIMEOUT - 1));

    // Shift register with the current bit placed at its MSB-first position.
    // Bits past WIDTH are dropped, which truncates long slots; positions
    // never written stay zero, which pads short slots.
    always_comb begin
        w_word = r_shreg;
        for (int i = 0; i < WIDTH; i++) begin
            if (int'(r_bitcnt) < WIDTH && i == WIDTH - 1 - int'(r_bitcnt)) begin
                w_word[i] = r_din_s2;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        r_sample_valid <= 1'b0;
        r_frame_err    <= 1'b0;
        if (i_reset) begin
            r_bclk_s1   <= 1'b0;
            r_bclk_s2   <= 1'b0;
            r_bclk_s3   <= 1'b0;
            r_lrclk_s1  <= 1'b0;
            r_lrclk_s2  <= 1'b0;
            r_din_s1    <= 1'b0;
            r_din_s2    <= 1'b0;
            r_shreg     <= '0;
            r_left_pend <= '0;
            r_bitcnt    <= '0;
            r_ws_prev   <= 1'b0;
            r_synced    <= 1'b0;
            r_have_left <= 1'b0;
            r_to_cnt    <= '0;
            r_audio_l   <= '0;
            r_audio_r   <= '0;
            r_active    <= 1'b0;
        end else begin
            r_bclk_s1  <= i_i2s_bclk;
            r_bclk_s2  <= r_bclk_s1;
            r_bclk_s3  <= r_bclk_s2;
            r_lrclk_s1 <= i_i2s_lrclk;
            r_lrclk_s2 <= r_lrclk_s1;
            r_din_s1   <= i_i2s_din;
            r_din_s2   <= r_din_s1;

            if (w_rise) begin
                r_to_cnt <= '0;
                if (w_boundary) begin
                    // The bit sampled on the LRCLK change is the LSB of
                    // the word that just ended, so w_word is that word.
                    if (r_synced) begin
                        if (!r_ws_prev) begin
                            r_left_pend <= w_word;
                            r_have_left <= 1'b1;
                        end else if (r_have_left) begin
                            r_audio_l      <= r_left_pend;
                            r_audio_r      <= w_word;
                            r_sample_valid <= 1'b1;
                            r_have_left    <= 1'b0;
                        end
                        if (int'(r_bitcnt) + 1 < WIDTH) begin
                            r_frame_err <= 1'b1;
                        end
                    end
                    // The first boundary after reset or loss only syncs.
                    r_shreg   <= '0;
                    r_bitcnt  <= '0;
                    r_ws_prev <= r_lrclk_s2;
                    r_synced  <= 1'b1;
                    r_active  <= 1'b1;
                end else begin
                    r_shreg <= w_word;
                    if (r_bitcnt != 6'd63) begin
                        r_bitcnt <= r_bitcnt + 6'd1;
                    end
                end
            end else begin
                if (w_to_hit) begin
                    // Link lost: drop sync and any half pair, keep outputs.
                    r_synced    <= 1'b0;
                    r_have_left <= 1'b0;
                    r_active    <= 1'b0;
                    r_bitcnt    <= '0;
                end
                if (r_to_cnt != TW'(TIMEOUT)) begin
                    r_to_cnt <= r_to_cnt + 1'b1;
                end
            end
        end
    end

    assign o_audio_l      = r_audio_l;
    assign o_audio_r      = r_audio_r;
    assign o_sample_valid = r_sample_valid;
    assign o_frame_err    = r_frame_err;
    assign o_active       = r_active;

endmodule

// File: tb/tb_i2s_receiver.sv
// ---------------------------------------------------------------------------
// tb_i2s_receiver
//
// Drives Philips I2S frames into i2s_receiver with BCLK = clk/16. Each frame
// task pushes the hand-computed {left,right} pair it should produce onto
// exp_q; a monitor process pops and compares whenever o_sample_valid is high.
// ---------------------------------------------------------------------------
module tb_i2s_receiver;

    localparam int WIDTH   = 16;
    localparam int TIMEOUT = 1024;
    localparam int HALF    = 8;

    logic             clk = 1'b0;
    logic             i_reset;
    logic             i_i2s_bclk;
    logic             i_i2s_lrclk;
    logic             i_i2s_din;
    logic [WIDTH-1:0] o_audio_l;
    logic [WIDTH-1:0] o_audio_r;
    logic             o_sample_valid;
    logic             o_frame_err;
    logic             o_active;

    i2s_receiver #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .i_clk          (clk),
        .i_reset        (i_reset),
        .i_i2s_bclk     (i_i2s_bclk),
        .i_i2s_lrclk    (i_i2s_lrclk),
        .i_i2s_din      (i_i2s_din),
        .o_audio_l      (o_audio_l),
        .o_audio_r      (o_audio_r),
        .o_sample_valid (o_sample_valid),
        .o_frame_err    (o_frame_err),
        .o_active       (o_active)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    logic [2*WIDTH-1:0] exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   err_cnt = 0;
    logic pend_lsb = 1'b0;
    int   last_rise_cyc = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        repeat (3) @(negedge clk);
        i_reset = 1'b0;
        pend_lsb = 1'b0;
        @(negedge clk);
    endtask

    // ---------------- driver tasks ----------------
    // One BCLK period; data and word select change while BCLK is low.
    task automatic bit_out(input logic ws, input logic d);
        i_i2s_lrclk = ws;
        i_i2s_din   = d;
        repeat (HALF) @(negedge clk);
        i_i2s_bclk    = 1'b1;
        last_rise_cyc = cyc;
        repeat (HALF) @(negedge clk);
        i_i2s_bclk = 1'b0;
    endtask

    // A slot of n periods: the first carries the previous word's LSB,
    // then bits n-1..1 of this word; this word's LSB opens the next slot.
    task automatic send_word(input logic ws, input int n, input logic [63:0] data);
        bit_out(ws, pend_lsb);
        for (int i = n - 1; i >= 1; i--) bit_out(ws, data[i]);
        pend_lsb = data[0];
    endtask

    task automatic send_frame(input int n, input logic [63:0] l, input logic [63:0] r,
                              input bit push, input logic [WIDTH-1:0] el,
                              input logic [WIDTH-1:0] er);
        if (push) exp_q.push_back({el, er});
        send_word(1'b0, n, l);
        send_word(1'b1, n, r);
    endtask

    // Opens a left slot so the last right word sees its boundary.
    task automatic close_stream(input int n);
        send_word(1'b0, n, 64'h0);
        repeat (8) @(negedge clk);
    endtask

    // ---------------- main sequence + monitor ----------------
    int   err_base;
    int   fall_cyc;
    bit   found;
    logic [WIDTH-1:0] held_l, held_r;

    initial begin
        i_reset     = 1'b1;
        i_i2s_bclk  = 1'b0;
        i_i2s_lrclk = 1'b0;
        i_i2s_din   = 1'b0;

        // Monitor: pops one expected pair per strobe, counts frame errors.
        fork
            begin
                logic prev_sv = 1'b0;
                logic prev_fe = 1'b0;
                logic [2*WIDTH-1:0] e;
                forever begin
                    @(negedge clk);
                    if (!i_reset) begin
                        if (o_sample_valid) begin
                            check("sv_one_cycle", prev_sv, 0);
                            if (exp_q.size() == 0) begin
                                check("unexpected_valid", {o_audio_l, o_audio_r}, 64'hDEAD_0000_0000);
                            end else begin
                                e = exp_q.pop_front();
                                check("pair", {o_audio_l, o_audio_r}, e);
                            end
                        end
                        if (o_frame_err) begin
                            err_cnt++;
                            check("fe_one_cycle", prev_fe, 0);
                        end
                    end
                    prev_sv = o_sample_valid;
                    prev_fe = o_frame_err;
                end
            end
        join_none

        repeat (3) @(negedge clk);
        i_reset = 1'b0;
        @(negedge clk);

        // Reset state.
        check("rst_audio_l", o_audio_l, 0);
        check("rst_audio_r", o_audio_r, 0);
        check("rst_valid", o_sample_valid, 0);
        check("rst_frame_err", o_frame_err, 0);
        check("rst_active", o_active, 0);

        // Test 1: 16-bit slots; frame 1 only syncs/drops, later frames pair.
        do_reset();
        err_base = err_cnt;
        send_frame(16, 64'h1234, 64'hABCD, 0, 16'h0, 16'h0);
        for (int k = 0; k < 3; k++) send_frame(16, 64'h1234, 64'hABCD, 1, 16'h1234, 16'hABCD);
        close_stream(16);
        check("t1_queue_empty", exp_q.size(), 0);
        check("t1_frame_err", err_cnt - err_base, 0);
        check("t1_active", o_active, 1);
        check("t1_hold_l", o_audio_l, 16'h1234);

        // Test 2: 32-bit slots truncate to the top 16 bits.
        do_reset();
        err_base = err_cnt;
        send_frame(32, 64'h8001_FFFF, 64'h7FFE_0000, 0, 16'h0, 16'h0);
        for (int k = 0; k < 2; k++) send_frame(32, 64'h8001_FFFF, 64'h7FFE_0000, 1, 16'h8001, 16'h7FFE);
        close_stream(32);
        check("t2_queue_empty", exp_q.size(), 0);
        check("t2_frame_err", err_cnt - err_base, 0);

        // Test 3: 8-bit slots zero-pad; five synced boundaries, five errors.
        do_reset();
        err_base = err_cnt;
        send_frame(8, 64'h12, 64'hF0, 0, 16'h0, 16'h0);
        for (int k = 0; k < 2; k++) send_frame(8, 64'h12, 64'hF0, 1, 16'h1200, 16'hF000);
        close_stream(8);
        check("t3_queue_empty", exp_q.size(), 0);
        check("t3_frame_err", err_cnt - err_base, 5);

        // Test 4: BCLK stops. The internal rise is two clk after BCLK goes
        // high and the loss lands TIMEOUT cycles after that rise is seen.
        do_reset();
        send_frame(16, 64'h1111, 64'h9999, 0, 16'h0, 16'h0);
        send_frame(16, 64'h2222, 64'h3333, 1, 16'h2222, 16'h3333);
        close_stream(16);
        check("t4_queue_empty", exp_q.size(), 0);
        check("t4_active_before", o_active, 1);
        found = 0;
        for (int n = 0; n < 1500 && !found; n++) begin
            @(negedge clk);
            if (!o_active) begin
                found    = 1;
                fall_cyc = cyc;
            end
        end
        check("t4_active_fell", found, 1);
        if (found) check("t4_timeout_cycles", fall_cyc - last_rise_cyc, TIMEOUT + 3);
        while (cyc - last_rise_cyc < 1100) @(negedge clk);
        check("t4_held_l", o_audio_l, 16'h2222);
        check("t4_held_r", o_audio_r, 16'h3333);
        send_frame(16, 64'h4444, 64'h6666, 0, 16'h0, 16'h0);
        send_frame(16, 64'h5555, 64'h0F0F, 1, 16'h5555, 16'h0F0F);
        close_stream(16);
        check("t4_restart_queue_empty", exp_q.size(), 0);

        // Test 5: reset in the middle of a left word.
        for (int k = 0; k < 5; k++) bit_out(1'b0, 1'b1);
        do_reset();
        check("t5_rst_l", o_audio_l, 0);
        check("t5_rst_r", o_audio_r, 0);
        check("t5_rst_active", o_active, 0);
        send_frame(16, 64'hAAAA, 64'h5555, 0, 16'h0, 16'h0);
        send_frame(16, 64'h1357, 64'h2468, 1, 16'h1357, 16'h2468);
        check("t5_still_zero_l", o_audio_l, 0);
        check("t5_still_zero_r", o_audio_r, 0);
        close_stream(16);
        check("t5_queue_empty", exp_q.size(), 0);

        // Test 6: ramp on both channels, in order with no gaps.
        do_reset();
        err_base = err_cnt;
        for (int k = 0; k < 8; k++) begin
            send_frame(16, 64'(k), 64'(k), k >= 1, 16'(k), 16'(k));
        end
        close_stream(16);
        check("t6_queue_empty", exp_q.size(), 0);
        check("t6_frame_err", err_cnt - err_base, 0);
        check("t6_last_l", o_audio_l, 16'h0007);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
